comp_nbit_seq: RTL

Parametrised sequential magnitude comparator: compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and terminates early on the first unequal digit. It generalises the combinational 1-/2-bit comparators to arbitrary width, adds signed/unsigned mode, and wraps the result in a valid/ready handshake. It is intended for area-constrained datapaths where a full-width combinational compare is too large or too slow.

---
 rtl/comp_pkg.sv | 27 ++
 rtl/comp_digit.sv | 16 +
 rtl/comp_nbit_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package comp_pkg;

  // Controller states: wait for operands, walk digits MSB-first, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot result encoding, ordered {gt, eq, lt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Width of a counter that must hold the values 0..ndig.
  function automatic int cycles_w(input int ndig);
    return $clog2(ndig + 1);
  endfunction

  // Width of a digit index 0..ndig-1; never zero so NDIG=1 still gets a bit.
  function automatic int idx_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
module comp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/comp_nbit_seq.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per clock, with
// early termination on the first unequal digit and signed/unsigned mode.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE (and never during rst); operands
// are captured on that edge. out_valid is high only in DONE; the result and
// cycles stay frozen until the edge where out_ready is seen high.
module comp_nbit_seq
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      a,
  input  logic [WIDTH-1:0]                      b,
  input  logic                                  signed_mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  gt,
  output logic                                  eq,
  output logic                                  lt,
  output logic [cycles_w(WIDTH/DIGIT)-1:0]      cycles
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cycles_w(NDIG);
  localparam int IW   = idx_w(NDIG);
  localparam logic [IW-1:0]    TOP_IDX  = IW'(NDIG - 1);
  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  // Operands must split into whole digits.
  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("comp_nbit_seq: WIDTH must be a multiple of DIGIT");
  end

  // FSM state, kept as a plainly named signal for probing.
  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cycles_q;
  logic [2:0]       res_q;

  logic [NDIG-1:0][DIGIT-1:0] a_digits;
  logic [NDIG-1:0][DIGIT-1:0] b_digits;
  logic [DIGIT-1:0]           flip;
  logic [DIGIT-1:0]           a_dig;
  logic [DIGIT-1:0]           b_dig;
  logic                       d_gt;
  logic                       d_eq;
  logic                       d_lt;
  logic                       accept;

  assign a_digits = a_q;
  assign b_digits = b_q;

  // Offset-binary trick: flipping the sign bit of both operands turns a
  // two's-complement compare into an unsigned one; only the top digit holds it.
  assign flip  = (signed_q && (idx == TOP_IDX)) ? MSB_MASK : '0;
  assign a_dig = a_digits[idx] ^ flip;
  assign b_dig = b_digits[idx] ^ flip;

  comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .gt (d_gt),
    .eq (d_eq),
    .lt (d_lt)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign gt        = res_q[2] && out_valid;
  assign eq        = res_q[1] && out_valid;
  assign lt        = res_q[0] && out_valid;
  assign cycles    = cycles_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: leave RUN on the first unequal digit or after digit 0.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = RUN;
      RUN:  if (!d_eq || (idx == '0)) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, digit walk, cycle count and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      cycles_q <= '0;
      res_q    <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx      <= TOP_IDX;
            cycles_q <= '0;
            res_q    <= RES_NONE;
          end
        end
        RUN: begin
          cycles_q <= cycles_q + CW'(1);
          if (d_gt)              res_q <= RES_GT;
          else if (d_lt)         res_q <= RES_LT;
          else if (idx == '0)    res_q <= RES_EQ;
          else                   idx   <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
